// File: rtl/cla_bist_checker.sv
// cla_bist_checker: self-test driver/checker for an N-bit combinational CLA adder.
// Two Galois LFSRs produce the operand pairs. The adder result {cout,sum} is compared
// against a behavioural a+b+cin. The block reports pass/fail, the error count and the
// index of the first failing vector.
module cla_bist_checker #(
  parameter int unsigned N           = 32,
  parameter int unsigned NUM_VECTORS = 64,
  parameter logic [31:0] SEED_A      = 32'hACE1_1234,
  parameter logic [31:0] SEED_B      = 32'h1357_BEEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [15:0]  err_count,
  output logic [15:0]  vec_count,
  output logic [15:0]  fail_idx,
  output logic [N-1:0] dut_a,
  output logic [N-1:0] dut_b,
  output logic         dut_cin,
  input  logic [N-1:0] dut_sum,
  input  logic         dut_cout
);

  if (N != 16 && N != 32) begin : g_bad_width
    $error("cla_bist_checker: N must be 16 or 32");
  end
  if (NUM_VECTORS > 65535) begin : g_bad_count
    $error("cla_bist_checker: NUM_VECTORS must be 0..65535");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [N-1:0] MASK   = (N == 32) ? N'(32'h8020_0003) : N'(32'h0000_B400);
  localparam logic [N-1:0] SA_RAW = SEED_A[N-1:0];
  localparam logic [N-1:0] SB_RAW = SEED_B[N-1:0];
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [N-1:0] SA     = (SA_RAW == '0) ? N'(1) : SA_RAW;
  localparam logic [N-1:0] SB     = (SB_RAW == '0) ? N'(1) : SB_RAW;
  localparam logic [15:0]  LAST_IDX = (NUM_VECTORS == 0) ? 16'hFFFF : 16'(NUM_VECTORS - 1);

  state_t       state, state_next;
  logic         launch;
  logic         mismatch;
  logic [N:0]   expected;
  logic [15:0]  vec_count_next;

  // Galois LFSR step: shift right and apply the tap mask when the bit shifted out is 1.
  function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] x);
    return x[0] ? ((x >> 1) ^ MASK) : (x >> 1);
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode. A start request launches a run from IDLE or DONE and is ignored in RUN.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          launch     = 1'b1;
          state_next = (NUM_VECTORS == 0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (vec_count == LAST_IDX) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Reference sum for the vector currently presented to the adder
  always_comb begin
    expected       = {1'b0, dut_a} + {1'b0, dut_b} + {{N{1'b0}}, dut_cin};
    mismatch       = ({dut_cout, dut_sum} != expected);
    vec_count_next = vec_count + 16'd1;
  end

  // Operand generation and result bookkeeping. The operand registers also act as the LFSR state.
  always_ff @(posedge clk) begin
    if (rst) begin
      dut_a     <= '0;
      dut_b     <= '0;
      dut_cin   <= 1'b0;
      vec_count <= '0;
      err_count <= '0;
      fail_idx  <= '1;
    end else if (launch) begin
      dut_a     <= SA;
      dut_b     <= SB;
      dut_cin   <= 1'b0;
      vec_count <= '0;
      err_count <= '0;
      fail_idx  <= '1;
    end else if (state == RUN) begin
      if (mismatch) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (fail_idx == 16'hFFFF)  fail_idx  <= vec_count;
      end
      // The edge that checks the last vector leaves the operands on the bus unchanged.
      if (vec_count != LAST_IDX) begin
        dut_a     <= lfsr_step(dut_a);
        dut_b     <= lfsr_step(dut_b);
        vec_count <= vec_count_next;
        dut_cin   <= vec_count_next[0];
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = done && (err_count == 16'd0);

endmodule

// File: tb/tb_cla_bist_checker.sv
// Directed bench for cla_bist_checker. It uses five instances that differ in width,
// vector count, seeds and attached adder model (correct or faulty).
module tb_cla_bist_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // u0: 32-bit, 8 vectors, correct adder
  logic start0 = 1'b0, busy0, done0, pass0, cin0, cout0;
  logic [15:0] err0, vec0, fidx0;
  logic [31:0] a0, b0, sum0;
  assign {cout0, sum0} = {1'b0, a0} + {1'b0, b0} + {32'b0, cin0};
  cla_bist_checker #(.N(32), .NUM_VECTORS(8)) u0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .vec_count(vec0), .fail_idx(fidx0), .dut_a(a0), .dut_b(b0),
    .dut_cin(cin0), .dut_sum(sum0), .dut_cout(cout0));

  // u1: 32-bit, 8 vectors, adder with sum bit 0 inverted
  logic start1 = 1'b0, busy1, done1, pass1, cin1, cout1;
  logic [15:0] err1, vec1, fidx1;
  logic [31:0] a1, b1, sum1, sum1_raw;
  assign {cout1, sum1_raw} = {1'b0, a1} + {1'b0, b1} + {32'b0, cin1};
  assign sum1 = sum1_raw ^ 32'd1;
  cla_bist_checker #(.N(32), .NUM_VECTORS(8)) u1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .vec_count(vec1), .fail_idx(fidx1), .dut_a(a1), .dut_b(b1),
    .dut_cin(cin1), .dut_sum(sum1), .dut_cout(cout1));

  // u2: corner seeds, 1 vector, carry-out stuck at 0
  logic start2 = 1'b0, busy2, done2, pass2, cin2;
  logic [15:0] err2, vec2, fidx2;
  logic [31:0] a2, b2, sum2;
  assign sum2 = a2 + b2 + {31'b0, cin2};
  cla_bist_checker #(.N(32), .NUM_VECTORS(1), .SEED_A(32'hFFFF_FFFF), .SEED_B(32'h0000_0001)) u2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .vec_count(vec2), .fail_idx(fidx2), .dut_a(a2), .dut_b(b2),
    .dut_cin(cin2), .dut_sum(sum2), .dut_cout(1'b0));

  // u3: zero-length run
  logic start3 = 1'b0, busy3, done3, pass3, cin3, cout3;
  logic [15:0] err3, vec3, fidx3;
  logic [31:0] a3, b3, sum3;
  assign {cout3, sum3} = {1'b0, a3} + {1'b0, b3} + {32'b0, cin3};
  cla_bist_checker #(.N(32), .NUM_VECTORS(0)) u3 (
    .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .vec_count(vec3), .fail_idx(fidx3), .dut_a(a3), .dut_b(b3),
    .dut_cin(cin3), .dut_sum(sum3), .dut_cout(cout3));

  // u4: 16-bit, 8 vectors, correct adder
  logic start4 = 1'b0, busy4, done4, pass4, cin4, cout4;
  logic [15:0] err4, vec4, fidx4;
  logic [15:0] a4, b4, sum4;
  assign {cout4, sum4} = {1'b0, a4} + {1'b0, b4} + {16'b0, cin4};
  cla_bist_checker #(.N(16), .NUM_VECTORS(8)) u4 (
    .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4), .pass(pass4),
    .err_count(err4), .vec_count(vec4), .fail_idx(fidx4), .dut_a(a4), .dut_b(b4),
    .dut_cin(cin4), .dut_sum(sum4), .dut_cout(cout4));

  // First four LFSR-A states, worked out by hand from the seeds and tap masks
  localparam logic [31:0] TBL32 [4] = '{32'hACE1_1234, 32'h5670_891A, 32'h2B38_448D, 32'h95BC_2245};
  localparam logic [31:0] TBL16 [4] = '{32'h0000_1234, 32'h0000_091A, 32'h0000_048D, 32'h0000_B646};

  function automatic logic [31:0] model_step(input logic [31:0] x, input bit w16);
    logic [15:0] x16;
    if (w16) begin
      x16 = x[15:0];
      return x16[0] ? {16'b0, (x16 >> 1) ^ 16'hB400} : {16'b0, x16 >> 1};
    end
    return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
  endfunction

  // Checks an 8-vector run of u0 (or u4 when w16) starting at the negedge right after E0,
  // then the DONE state one negedge after the last vector.
  task automatic run_check(input string tag, input bit w16);
    logic [31:0] ea, eb, ga, gb;
    logic [31:0] seen [8];
    logic gcin, gbusy, gdone;
    logic [15:0] gvec;
    int distinct;
    ea = w16 ? 32'h0000_1234 : 32'hACE1_1234;
    eb = w16 ? 32'h0000_BEEF : 32'h1357_BEEF;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      ga = w16 ? {16'b0, a4} : a0;
      gb = w16 ? {16'b0, b4} : b0;
      gcin = w16 ? cin4 : cin0;
      gbusy = w16 ? busy4 : busy0;
      gdone = w16 ? done4 : done0;
      gvec = w16 ? vec4 : vec0;
      seen[k] = ga;
      check_eq($sformatf("%s_a%0d", tag, k), ga, (k < 4) ? (w16 ? TBL16[k] : TBL32[k]) : ea);
      check_eq($sformatf("%s_b%0d", tag, k), gb, eb);
      check_eq($sformatf("%s_cin%0d", tag, k), gcin, k % 2);
      check_eq($sformatf("%s_vec%0d", tag, k), gvec, k);
      check_eq($sformatf("%s_busy%0d", tag, k), {gbusy, gdone}, 2'b10);
      ea = model_step(ea, w16);
      eb = model_step(eb, w16);
    end
    distinct = 0;
    for (int i = 0; i < 8; i++) begin
      bit dup = 0;
      for (int j = 0; j < i; j++) if (seen[j] == seen[i]) dup = 1;
      if (!dup) distinct++;
    end
    check_eq({tag, "_distinct"}, distinct, 8);
    @(negedge clk);
    if (w16) begin
      check_eq({tag, "_end_flags"}, {busy4, done4, pass4}, 3'b011);
      check_eq({tag, "_end_err"}, err4, 16'd0);
      check_eq({tag, "_end_fidx"}, fidx4, 16'hFFFF);
      check_eq({tag, "_end_vec"}, vec4, 16'd7);
    end else begin
      check_eq({tag, "_end_flags"}, {busy0, done0, pass0}, 3'b011);
      check_eq({tag, "_end_err"}, err0, 16'd0);
      check_eq({tag, "_end_fidx"}, fidx0, 16'hFFFF);
      check_eq({tag, "_end_vec"}, vec0, 16'd7);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    // Reset state
    check_eq("rst_flags", {busy0, done0, pass0}, 3'b000);
    check_eq("rst_err", err0, 16'd0);
    check_eq("rst_vec", vec0, 16'd0);
    check_eq("rst_fidx", fidx0, 16'hFFFF);
    check_eq("rst_ops", {a0, b0, cin0}, 65'd0);
    rst = 1'b0;

    // Correct 32-bit adder, 8 vectors
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    run_check("t1", 1'b0);

    // Sum bit 0 inverted: every vector fails
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    check_eq("t2_fidx_pre", fidx1, 16'hFFFF);
    repeat (8) @(negedge clk);
    check_eq("t2_flags", {busy1, done1, pass1}, 3'b010);
    check_eq("t2_err", err1, 16'd8);
    check_eq("t2_fidx", fidx1, 16'd0);

    // Corner seeds with cout stuck at 0
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    check_eq("t3_busy", busy2, 1'b1);
    check_eq("t3_ops", {a2, b2, cin2}, {32'hFFFF_FFFF, 32'h0000_0001, 1'b0});
    check_eq("t3_exp", {1'b0, a2} + {1'b0, b2} + {32'b0, cin2}, 33'h1_0000_0000);
    @(negedge clk);
    check_eq("t3_flags", {busy2, done2, pass2}, 3'b010);
    check_eq("t3_err", err2, 16'd1);
    check_eq("t3_fidx", fidx2, 16'd0);

    // Zero-length run: straight to DONE with pass, never busy
    @(negedge clk) start3 = 1'b1;
    @(negedge clk) start3 = 1'b0;
    check_eq("t6_flags0", {busy3, done3, pass3}, 3'b011);
    @(negedge clk);
    check_eq("t6_flags1", {busy3, done3, pass3}, 3'b011);
    check_eq("t6_fidx", fidx3, 16'hFFFF);

    // 16-bit variant
    @(negedge clk) start4 = 1'b1;
    @(negedge clk) start4 = 1'b0;
    run_check("t6w16", 1'b1);

    // Reset sampled at E0+3 aborts the run
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t4_flags", {busy0, done0, pass0}, 3'b000);
    check_eq("t4_err", err0, 16'd0);
    check_eq("t4_vec", vec0, 16'd0);
    check_eq("t4_a", a0, 32'd0);
    rst = 1'b0;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    run_check("t4rerun", 1'b0);

    // start held high: ignored in RUN, restarts from DONE on the next edge
    @(negedge clk) start0 = 1'b1;
    @(negedge clk);
    run_check("t5first", 1'b0);
    @(negedge clk) start0 = 1'b0;
    run_check("t5second", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
